// File: rtl/fir_stereo_pkg.sv
// rtl/fir_stereo_pkg.sv - shared types and default widths for the stereo merge block
package fir_stereo_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_OUT_W    = 24;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_SKEW_MAX = 64;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] l;
        logic [DEF_DATA_W-1:0] r;
    } stereo_pair_t;

    typedef enum logic [1:0] {
        IDLE,
        HAVE_L,
        HAVE_R
    } pair_state_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous show-ahead FIFO with registered storage and occupancy
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));
    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;

    // A full FIFO still accepts a push when the same cycle pops a slot free.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/fir_stereo_merge.sv
// rtl/fir_stereo_merge.sv - pairs skewed left/right filter strobes into buffered codec writes
module fir_stereo_merge
    import fir_stereo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int SKEW_MAX = DEF_SKEW_MAX
) (
    input  logic                    ck,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       left_in,
    input  logic                    left_ready,
    input  logic [DATA_W-1:0]       right_in,
    input  logic                    right_ready,
    input  logic                    write_ready,
    output logic                    write,
    output logic [OUT_W-1:0]        writedata_left,
    output logic [OUT_W-1:0]        writedata_right,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    pair_err
);
    localparam int SKEW_W = $clog2(SKEW_MAX);
    localparam logic [SKEW_W-1:0] SKEW_LAST = SKEW_W'(SKEW_MAX - 1);

    pair_state_t       state_q, state_d;
    logic [DATA_W-1:0] held_l_q, held_l_d;
    logic [DATA_W-1:0] held_r_q, held_r_d;
    logic [SKEW_W-1:0] skew_q, skew_d;
    logic              pair_err_q, pair_err_d;
    logic              overflow_q, overflow_d;

    logic                push;
    logic [DATA_W-1:0]   push_l, push_r;
    logic [2*DATA_W-1:0] head;
    logic                full, empty;

    sample_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .ck        (ck),
        .rst       (rst),
        .push      (push),
        .push_data ({push_l, push_r}),
        .pop       (write),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign write           = write_ready & ~empty;
    assign writedata_left  = {head[2*DATA_W-1:DATA_W], {(OUT_W-DATA_W){1'b0}}};
    assign writedata_right = {head[DATA_W-1:0], {(OUT_W-DATA_W){1'b0}}};
    assign overflow        = overflow_q;
    assign pair_err        = pair_err_q;

    always_comb begin
        state_d    = state_q;
        held_l_d   = held_l_q;
        held_r_d   = held_r_q;
        skew_d     = '0;
        pair_err_d = pair_err_q;
        push       = 1'b0;
        push_l     = left_in;
        push_r     = right_in;
        case (state_q)
            IDLE: begin
                if (left_ready && right_ready) begin
                    push = 1'b1;
                end else if (left_ready) begin
                    held_l_d = left_in;
                    state_d  = HAVE_L;
                end else if (right_ready) begin
                    held_r_d = right_in;
                    state_d  = HAVE_R;
                end
            end
            HAVE_L: begin
                skew_d = skew_q + 1'b1;
                if (right_ready) begin
                    push   = 1'b1;
                    push_l = held_l_q;
                    if (left_ready) begin
                        held_l_d = left_in;
                        skew_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (left_ready) begin
                    held_l_d   = left_in;
                    pair_err_d = 1'b1;
                    skew_d     = '0;
                end else if (skew_q == SKEW_LAST) begin
                    pair_err_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            HAVE_R: begin
                skew_d = skew_q + 1'b1;
                if (left_ready) begin
                    push   = 1'b1;
                    push_r = held_r_q;
                    if (right_ready) begin
                        held_r_d = right_in;
                        skew_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (right_ready) begin
                    held_r_d   = right_in;
                    pair_err_d = 1'b1;
                    skew_d     = '0;
                end else if (skew_q == SKEW_LAST) begin
                    pair_err_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A pop frees a slot, so only a push without a same-cycle write can be lost.
        overflow_d = overflow_q | (push & full & ~write);
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q    <= IDLE;
            held_l_q   <= '0;
            held_r_q   <= '0;
            skew_q     <= '0;
            pair_err_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_l_q   <= held_l_d;
            held_r_q   <= held_r_d;
            skew_q     <= skew_d;
            pair_err_q <= pair_err_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_fir_stereo_merge.sv
// tb/tb_fir_stereo_merge.sv - directed self-checking bench for fir_stereo_merge
module tb_fir_stereo_merge;
    import fir_stereo_pkg::*;

    logic        ck;
    logic        rst;
    logic [15:0] left_in;
    logic        left_ready;
    logic [15:0] right_in;
    logic        right_ready;
    logic        write_ready;
    logic        write;
    logic [23:0] writedata_left;
    logic [23:0] writedata_right;
    logic [2:0]  level;
    logic        overflow;
    logic        pair_err;

    int n_checks = 0;
    int n_fail   = 0;

    fir_stereo_merge dut (
        .ck              (ck),
        .rst             (rst),
        .left_in         (left_in),
        .left_ready      (left_ready),
        .right_in        (right_in),
        .right_ready     (right_ready),
        .write_ready     (write_ready),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .level           (level),
        .overflow        (overflow),
        .pair_err        (pair_err)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic idle_inputs();
        left_ready  = 1'b0;
        right_ready = 1'b0;
        left_in     = '0;
        right_in    = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        write_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b expected 0", write); end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (pair_err !== 1'b0) begin n_fail++; $display("FAIL reset_pair_err: got %b expected 0", pair_err); end
        n_checks++; if (writedata_left !== 24'h0 || writedata_right !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h expected 000000/000000", writedata_left, writedata_right); end
    endtask

    task automatic test_same_cycle();
        write_ready = 1'b1;
        left_in = 16'h1234; right_in = 16'hABCD;
        left_ready = 1'b1; right_ready = 1'b1;
        tick();
        idle_inputs();
        n_checks++; if (write !== 1'b1) begin n_fail++; $display("FAIL same_write: got %b expected 1", write); end
        n_checks++; if (writedata_left !== 24'h123400) begin n_fail++; $display("FAIL same_left: got %h expected 123400", writedata_left); end
        n_checks++; if (writedata_right !== 24'hABCD00) begin n_fail++; $display("FAIL same_right: got %h expected abcd00", writedata_right); end
        tick();
        n_checks++; if (level !== 3'd0 || write !== 1'b0) begin n_fail++; $display("FAIL same_drain: got level %0d write %b expected 0 0", level, write); end
    endtask

    task automatic test_skewed_pair();
        int writes;
        writes = 0;
        write_ready = 1'b1;
        left_in = 16'h8001; left_ready = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 9; i++) begin
            if (write === 1'b1) writes++;
            tick();
        end
        right_in = 16'h7FFE; right_ready = 1'b1;
        if (write === 1'b1) writes++;
        tick();
        idle_inputs();
        n_checks++; if (writes !== 0) begin n_fail++; $display("FAIL skew_early_writes: got %0d expected 0", writes); end
        n_checks++; if (write !== 1'b1) begin n_fail++; $display("FAIL skew_write: got %b expected 1", write); end
        n_checks++; if (writedata_left !== 24'h800100 || writedata_right !== 24'h7FFE00) begin n_fail++; $display("FAIL skew_data: got %h/%h expected 800100/7ffe00", writedata_left, writedata_right); end
        tick();
        n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL skew_single_write: got %b expected 0", write); end
        n_checks++; if (pair_err !== 1'b0) begin n_fail++; $display("FAIL skew_pair_err: got %b expected 0", pair_err); end
    endtask

    task automatic test_timeout();
        write_ready = 1'b1;
        left_in = 16'h5555; left_ready = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 63; i++) tick();
        n_checks++; if (pair_err !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", pair_err); end
        tick();
        n_checks++; if (pair_err !== 1'b1) begin n_fail++; $display("FAIL timeout_pair_err: got %b expected 1", pair_err); end
        n_checks++; if (level !== 3'd0 || write !== 1'b0) begin n_fail++; $display("FAIL timeout_no_push: got level %0d write %b expected 0 0", level, write); end
        // R before L: a stale HAVE_L would pair the discarded 5555 with this R.
        right_in = 16'h2222; right_ready = 1'b1;
        tick();
        idle_inputs();
        left_in = 16'h1111; left_ready = 1'b1;
        tick();
        idle_inputs();
        n_checks++; if (write !== 1'b1 || writedata_left !== 24'h111100 || writedata_right !== 24'h222200) begin n_fail++; $display("FAIL timeout_repair: got %b %h/%h expected 1 111100/222200", write, writedata_left, writedata_right); end
        tick();
    endtask

    task automatic test_overflow();
        logic [15:0] v;
        write_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            v = 16'(i);
            left_in = v; right_in = v;
            left_ready = 1'b1; right_ready = 1'b1;
            tick();
        end
        idle_inputs();
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d expected 4", level); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL ovf_write_held: got %b expected 0", write); end
        write_ready = 1'b1;
        #1;
        for (int i = 1; i <= 4; i++) begin
            v = 16'(i);
            n_checks++; if (write !== 1'b1 || writedata_left !== {v, 8'h00} || writedata_right !== {v, 8'h00}) begin n_fail++; $display("FAIL ovf_drain_%0d: got %b %h/%h expected 1 %h", i, write, writedata_left, writedata_right, {v, 8'h00}); end
            tick();
        end
        n_checks++; if (level !== 3'd0 || write !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got level %0d write %b expected 0 0", level, write); end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] v;
        write_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = 16'h0010 + 16'(i);
            left_in = v; right_in = v;
            left_ready = 1'b1; right_ready = 1'b1;
            tick();
        end
        n_checks++; if (level !== 3'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL full_setup: got level %0d ovf %b expected 4 0", level, overflow); end
        left_in = 16'h0014; right_in = 16'h0014;
        write_ready = 1'b1;
        tick();
        idle_inputs();
        write_ready = 1'b0;
        #1;
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d expected 4", level); end
        n_checks++; if (writedata_left !== 24'h001100) begin n_fail++; $display("FAIL full_head: got %h expected 001100", writedata_left); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_overflow: got %b expected 0", overflow); end
        write_ready = 1'b1;
        #1;
        for (int i = 1; i <= 4; i++) begin
            v = 16'h0010 + 16'(i);
            n_checks++; if (write !== 1'b1 || writedata_right !== {v, 8'h00}) begin n_fail++; $display("FAIL full_drain_%0d: got %b %h expected 1 %h", i, write, writedata_right, {v, 8'h00}); end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        write_ready = 1'b0;
        left_in = 16'h0021; right_in = 16'h0021; left_ready = 1'b1; right_ready = 1'b1;
        tick();
        left_in = 16'h0022; right_in = 16'h0022;
        tick();
        idle_inputs();
        left_in = 16'h0030; left_ready = 1'b1;
        tick();
        left_in = 16'h0031;
        tick();
        idle_inputs();
        n_checks++; if (level !== 3'd2 || pair_err !== 1'b1) begin n_fail++; $display("FAIL rst_setup: got level %0d perr %b expected 2 1", level, pair_err); end
        rst = 1'b1;
        write_ready = 1'b1;
        right_in = 16'h0040; right_ready = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        n_checks++; if (level !== 3'd0 || write !== 1'b0) begin n_fail++; $display("FAIL rst_clear: got level %0d write %b expected 0 0", level, write); end
        n_checks++; if (pair_err !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got perr %b ovf %b expected 0 0", pair_err, overflow); end
        tick();
        tick();
        n_checks++; if (write !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL rst_strobe_ignored: got write %b level %0d expected 0 0", write, level); end
        // The held L (0031) must be gone: R then L pairs fresh values.
        right_in = 16'h0050; right_ready = 1'b1;
        tick();
        idle_inputs();
        left_in = 16'h0051; left_ready = 1'b1;
        tick();
        idle_inputs();
        n_checks++; if (write !== 1'b1 || writedata_left !== 24'h005100 || writedata_right !== 24'h005000) begin n_fail++; $display("FAIL rst_fresh_pair: got %b %h/%h expected 1 005100/005000", write, writedata_left, writedata_right); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        write_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_same_cycle();
        test_skewed_pair();
        test_timeout();
        test_overflow();
        test_reset();
        test_full_push_pop();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
